// File: rtl/rv_alu_ctrl_if.sv
// Handshake and payload bundle between the register-read stage, rv_alu_ctrl and rv_alu.
// The slave modport is the stage's view. The master modport is the driver/sink view.
`timescale 1ns/1ps

interface rv_alu_ctrl_if #(
  parameter int DW = 32
);
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic          funct7_5;
  logic [DW-1:0] rs1_val;
  logic [DW-1:0] rs2_val;
  logic [DW-1:0] imm;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    ALUop;
  logic [DW-1:0] in1;
  logic [DW-1:0] in2;
  logic          illegal;

  modport slave (
    input  flush, in_valid, opcode, funct3, funct7_5, rs1_val, rs2_val, imm, out_ready,
    output in_ready, out_valid, ALUop, in1, in2, illegal
  );

  modport master (
    output flush, in_valid, opcode, funct3, funct7_5, rs1_val, rs2_val, imm, out_ready,
    input  in_ready, out_valid, ALUop, in1, in2, illegal
  );
endinterface

// File: rtl/rv_alu_ctrl.sv
// ALU issue stage: decodes ALUop/operands with 1-cycle latency. An output + skid pair gives full rate under backpressure.
// in_ready is registered (skid empty). Optional custom-0 NOR is enabled by RV_ALU_CTRL_CUSTOM_NOR_EN.
`timescale 1ns/1ps

module rv_alu_ctrl #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  rv_alu_ctrl_if.slave  bus
);

  localparam logic [6:0] OPC_R       = 7'b0110011;
  localparam logic [6:0] OPC_I       = 7'b0010011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
`ifdef RV_ALU_CTRL_CUSTOM_NOR_EN
  localparam logic [3:0] OP_NOR = 4'b1100;
`endif

  typedef struct packed {
    logic [3:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          ill;
  } entry_t;

  logic [3:0]    dec_op;
  logic [DW-1:0] dec_a;
  logic [DW-1:0] dec_b;
  logic          dec_legal;
  entry_t        dec;

  entry_t        m_q;
  entry_t        s_q;
  logic          m_vld;
  logic          s_vld;
  logic          in_fire;
  logic          out_fire;

  always_comb begin
    dec_op    = OP_ADD;
    dec_a     = '0;
    dec_b     = '0;
    dec_legal = 1'b0;
    case (bus.opcode)
      OPC_R: begin
        dec_a     = bus.rs1_val;
        dec_b     = bus.rs2_val;
        dec_legal = 1'b1;
        case (bus.funct3)
          3'b000:  dec_op = bus.funct7_5 ? OP_SUB : OP_ADD;
          3'b111:  dec_op = OP_AND;
          3'b110:  dec_op = OP_OR;
          3'b010:  dec_op = OP_SLT;
          default: dec_legal = 1'b0;
        endcase
      end
      OPC_I: begin
        dec_a     = bus.rs1_val;
        dec_b     = bus.imm;
        dec_legal = 1'b1;
        case (bus.funct3)
          3'b000:  dec_op = OP_ADD;
          3'b111:  dec_op = OP_AND;
          3'b110:  dec_op = OP_OR;
          3'b010:  dec_op = OP_SLT;
          default: dec_legal = 1'b0;
        endcase
      end
      OPC_LOAD, OPC_STORE: begin
        dec_op    = OP_ADD;
        dec_a     = bus.rs1_val;
        dec_b     = bus.imm;
        dec_legal = 1'b1;
      end
      OPC_BRANCH: begin
        // Only BEQ/BNE: the comparison is carried by the zero flag of a subtract.
        dec_op    = OP_SUB;
        dec_a     = bus.rs1_val;
        dec_b     = bus.rs2_val;
        dec_legal = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001);
      end
      OPC_LUI: begin
        dec_op    = OP_ADD;
        dec_a     = '0;
        dec_b     = bus.imm;
        dec_legal = 1'b1;
      end
`ifdef RV_ALU_CTRL_CUSTOM_NOR_EN
      OPC_CUSTOM0: begin
        dec_op    = OP_NOR;
        dec_a     = bus.rs1_val;
        dec_b     = bus.rs2_val;
        dec_legal = (bus.funct3 == 3'b000);
      end
`else
      OPC_CUSTOM0: dec_legal = 1'b0;
`endif
      default: dec_legal = 1'b0;
    endcase

    // Illegal entries carry a neutral ADD of zeros so rv_alu sees harmless operands.
    dec.op  = dec_legal ? dec_op : OP_ADD;
    dec.a   = dec_legal ? dec_a  : '0;
    dec.b   = dec_legal ? dec_b  : '0;
    dec.ill = ~dec_legal;
  end

  assign in_fire  = bus.in_valid & ~s_vld;
  assign out_fire = m_vld & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_vld <= 1'b0;
      s_vld <= 1'b0;
      m_q   <= '0;
      s_q   <= '0;
    end else if (bus.flush) begin
      m_vld <= 1'b0;
      s_vld <= 1'b0;
    end else if (!m_vld || out_fire) begin
      if (s_vld) begin
        m_vld <= 1'b1;
        m_q   <= s_q;
      end else if (in_fire) begin
        m_vld <= 1'b1;
        m_q   <= dec;
      end else begin
        m_vld <= 1'b0;
      end
      s_vld <= s_vld & in_fire;
      if (s_vld & in_fire) begin
        s_q <= dec;
      end
    end else if (in_fire) begin
      s_vld <= 1'b1;
      s_q   <= dec;
    end
  end

  assign bus.out_valid = m_vld;
  assign bus.in_ready  = ~s_vld;
  assign bus.ALUop     = m_q.op;
  assign bus.in1       = m_q.a;
  assign bus.in2       = m_q.b;
  assign bus.illegal   = m_q.ill;

endmodule

// File: doc/rv_alu_ctrl.md
# rv_alu_ctrl

ALU issue stage for the RV32 core: accepts decoded instruction fields and register operands with a valid/ready handshake, generates the 4-bit `ALUop` code and the two ALU operands, and presents them registered to `rv_alu`. It sits between the register-file read stage and `rv_alu`, and drives the same `ALUop` encoding that `rv_alu` consumes. A two-entry (output + skid) buffer sustains one instruction per cycle under backpressure.

## Interface
- `DW`, 32, datapath width of operands and immediate.
- `clk`  input  1  single clock; everything samples on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `flush`  input  1  synchronous drop of all buffered entries.
- `in_valid`  input  1  upstream entry valid.
- `in_ready`  output  1  stage can accept; equals "skid entry empty".
- `opcode`  input  7  instruction bits [6:0].
- `funct3`  input  3  instruction bits [14:12].
- `funct7_5`  input  1  instruction bit 30.
- `rs1_val`, `rs2_val`, `imm`  input  DW each  register operands, sign-extended immediate.
- `out_valid`  output  1  registered entry valid toward `rv_alu`.
- `out_ready`  input  1  downstream accepts.
- `ALUop`  output  4  op code to `rv_alu`.
- `in1`, `in2`  output  DW each  ALU operands.
- `illegal`  output  1  entry did not decode to a supported ALU op.

## Operation
- Decode (`ALUop`, `in1`, `in2`), computed combinationally from inputs, stored on accept:
  - R-type 0110011: f3=000,f7_5=0 → ADD 0010; f3=000,f7_5=1 → SUB 0110; f3=111 → AND 0000; f3=110 → OR 0001; f3=010 → SLT 0111; `in1`=rs1, `in2`=rs2. Other f3 → illegal.
  - I-type 0010011: f3 000/111/110/010 → ADD/AND/OR/SLT, `in2`=imm; f7_5 ignored. Other f3 → illegal.
  - Load 0000011, store 0100011: ADD, `in1`=rs1, `in2`=imm (address).
  - Branch 1100011, f3 000 or 001: SUB, `in1`=rs1, `in2`=rs2 (downstream uses `zflag`). Other f3 → illegal.
  - LUI 0110111: ADD, `in1`=0, `in2`=imm.
  - Anything else: `illegal`=1, `ALUop`=0010, `in1`=`in2`=0. Illegal entries still flow through the handshake.
- Never emits an op outside {0000,0001,0010,0110,0111} except NOR under the macro.
- Buffer: output register M (drives outputs), skid register S.
  - in_fire = `in_valid & in_ready`; out_fire = `out_valid & out_ready`.
  - If M empty or out_fire: M ← S if S valid, else incoming if in_fire, else empty; S ← incoming if (S valid & in_fire), else empty.
  - Otherwise (M full, stalled): S ← incoming on in_fire.
  - `in_ready` = !S.valid (registered state, no combinational path from `out_ready`).
- `flush`: M and S become empty next edge; concurrent incoming entry dropped; has priority over all transfers.
- Outputs hold stable while `out_valid & !out_ready`.

## Timing
- Reset (async assert): `out_valid`=0, `in_ready`=1, `ALUop`=0000, `in1`=`in2`=0, `illegal`=0; M, S empty.
- Latency: entry accepted at edge N appears on outputs after edge N (1 cycle).
- Throughput: 1 entry/cycle with `out_ready` held high; S never fills.
- Single stall cycle fills S; `in_ready` drops the following cycle; resumes one cycle after S drains.
- Ordering strictly FIFO; no entry duplicated or lost except by `flush`/`rst`.
- `rst` mid-stream discards both entries immediately.

## Configuration
- `RV_ALU_CTRL_CUSTOM_NOR_EN` defined: opcode 0001011 (custom-0), f3=000 → NOR 1100, `in1`=rs1, `in2`=rs2, `illegal`=0; other f3 illegal.
- Not defined: opcode 0001011 is illegal like any unknown opcode; NOR never emitted.

## Test plan
- Reset while `in_valid`=1 → `out_valid`=0, `in_ready`=1, `ALUop`=0000, `in1`=`in2`=0.
- Back-to-back R-type SUB (rs1=7, rs2=3), ADDI (rs1=5, imm=0xFFFFFFFF), LUI (imm=0x12345000) with `out_ready`=1 → next cycles: (0110,7,3), (0010,5,0xFFFFFFFF), (0010,0,0x12345000); `in_ready` stays 1.
- Stream 4 entries, `out_ready`=0 for 2 cycles → `in_ready` drops after second accept; outputs hold entry 1; all 4 delivered in order after release.
- opcode 0110011 f3=001 and opcode 1100011 f3=100 → `illegal`=1, `ALUop`=0010, `in1`=`in2`=0.
- `flush` with M and S full and `in_valid`=1 → next cycle `out_valid`=0, `in_ready`=1, incoming entry absent.
- opcode 0001011 f3=000 → `ALUop`=1100, `illegal`=0 with macro; `illegal`=1, `ALUop`=0010 without.
